// File: rtl/frame_byte_tracker_pkg.sv
// Shared parser types: tracker FSM encoding and stream width helpers.
package frame_byte_tracker_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HDR   = 2'd2
  } tracker_state_e;

  function automatic int unsigned bytes_per_beat(input int unsigned width);
    return width / 8;
  endfunction

endpackage

// File: rtl/frame_byte_tracker_keep_popcount.sv
// Combinational popcount of a beat's byte-enable vector.
module keep_popcount #(
  parameter int BYTES_PER_BEAT = 8,
  localparam int PC_W = $clog2(BYTES_PER_BEAT + 1)
) (
  input  logic [BYTES_PER_BEAT-1:0] keep,
  output logic [PC_W-1:0]           count
);

  always_comb begin
    count = '0;
    for (int unsigned i = 0; i < BYTES_PER_BEAT; i++) begin
      count = count + PC_W'(keep[i]);
    end
  end

endmodule

// File: rtl/frame_byte_tracker.sv
// Per-frame byte tracker: start-of-frame detect, keep-aware byte count,
// header threshold flag and end-of-frame length with runt/oversize flags.
module frame_byte_tracker
  import frame_byte_tracker_pkg::*;
#(
  parameter int DATA_WIDTH      = 64,
  parameter int HEADER_BYTES    = 18,
  parameter int MAX_FRAME_BYTES = 1522,
  localparam int BYTES_PER_BEAT = bytes_per_beat(DATA_WIDTH),
  localparam int CNT_W          = $clog2(MAX_FRAME_BYTES + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      beat_accept,
  input  logic                      beat_last,
  input  logic [BYTES_PER_BEAT-1:0] beat_keep,
  output logic                      sof,
  output logic [CNT_W-1:0]          beat_offset,
  output logic                      header_done,
  output logic                      header_done_pulse,
  output logic                      frame_len_valid,
  output logic [CNT_W-1:0]          frame_len,
  output logic                      runt_err,
  output logic                      oversize_err
);

  localparam int PC_W = $clog2(BYTES_PER_BEAT + 1);

  if (DATA_WIDTH % 8 != 0) begin : g_bad_width
    $error("frame_byte_tracker: DATA_WIDTH must be a multiple of 8");
  end
  if (HEADER_BYTES > MAX_FRAME_BYTES) begin : g_bad_hdr
    $error("frame_byte_tracker: HEADER_BYTES exceeds MAX_FRAME_BYTES");
  end

  localparam logic [CNT_W:0]   MAX_EXT = (CNT_W + 1)'(MAX_FRAME_BYTES);
  localparam logic [CNT_W:0]   BPB_EXT = (CNT_W + 1)'(BYTES_PER_BEAT);
  localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_FRAME_BYTES);
  localparam logic [CNT_W-1:0] HDR_C   = CNT_W'(HEADER_BYTES);

  tracker_state_e   state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             pulse_q, pulse_d;
  logic             flv_q, flv_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             runt_q, runt_d;
  logic             over_q, over_d;

  logic [PC_W-1:0]  keep_cnt;
  logic [CNT_W:0]   add;
  logic [CNT_W:0]   sum;
  logic             over_now;
  logic [CNT_W-1:0] sat;

  keep_popcount #(.BYTES_PER_BEAT(BYTES_PER_BEAT)) u_keep_popcount (
    .keep  (beat_keep),
    .count (keep_cnt)
  );

  always_comb begin
    add      = beat_last ? (CNT_W + 1)'(keep_cnt) : BPB_EXT;
    sum      = {1'b0, count_q} + add;
    over_now = (sum > MAX_EXT);
    sat      = over_now ? MAX_C : sum[CNT_W-1:0];

    state_d = state_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    pulse_d = 1'b0;
    flv_d   = 1'b0;
    len_d   = len_q;
    runt_d  = runt_q;
    over_d  = over_q;

    if (beat_accept) begin
      if (beat_last) begin
        // Frame closes here; the threshold is never promoted to HDR on a last beat.
        flv_d   = 1'b1;
        len_d   = sat;
        runt_d  = (sat < HDR_C);
        over_d  = ovf_q | over_now;
        state_d = IDLE;
        count_d = '0;
        ovf_d   = 1'b0;
      end else begin
        count_d = sat;
        ovf_d   = ovf_q | over_now;
        if (state_q != HDR && sat >= HDR_C) begin
          state_d = HDR;
          pulse_d = 1'b1;
        end else if (state_q == IDLE) begin
          state_d = COUNT;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      ovf_q   <= 1'b0;
      pulse_q <= 1'b0;
      flv_q   <= 1'b0;
      len_q   <= '0;
      runt_q  <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      pulse_q <= pulse_d;
      flv_q   <= flv_d;
      len_q   <= len_d;
      runt_q  <= runt_d;
      over_q  <= over_d;
    end
  end

  assign sof               = beat_accept && (state_q == IDLE);
  assign beat_offset       = count_q;
  assign header_done       = (state_q == HDR);
  assign header_done_pulse = pulse_q;
  assign frame_len_valid   = flv_q;
  assign frame_len         = len_q;
  assign runt_err          = runt_q;
  assign oversize_err      = over_q;

endmodule

// File: tb/tb_frame_byte_tracker.sv
// Directed bench for frame_byte_tracker: default instance plus a 64-byte-limit instance.
module tb_frame_byte_tracker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       beat_accept = 1'b0;
  logic       beat_last = 1'b0;
  logic [7:0] beat_keep = '0;

  logic        sof, hd, hdp, flv, runt, over;
  logic [10:0] off, len;
  logic        sof_s, hd_s, hdp_s, flv_s, runt_s, over_s;
  logic [6:0]  off_s, len_s;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  frame_byte_tracker dut (
    .clk(clk), .rst(rst), .beat_accept(beat_accept), .beat_last(beat_last),
    .beat_keep(beat_keep), .sof(sof), .beat_offset(off), .header_done(hd),
    .header_done_pulse(hdp), .frame_len_valid(flv), .frame_len(len),
    .runt_err(runt), .oversize_err(over)
  );

  frame_byte_tracker #(.DATA_WIDTH(64), .HEADER_BYTES(18), .MAX_FRAME_BYTES(64)) dut_s (
    .clk(clk), .rst(rst), .beat_accept(beat_accept), .beat_last(beat_last),
    .beat_keep(beat_keep), .sof(sof_s), .beat_offset(off_s), .header_done(hd_s),
    .header_done_pulse(hdp_s), .frame_len_valid(flv_s), .frame_len(len_s),
    .runt_err(runt_s), .oversize_err(over_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic a, input logic l, input logic [7:0] k);
    beat_accept = a;
    beat_last   = l;
    beat_keep   = k;
  endtask

  task automatic beat(input logic l, input logic [7:0] k);
    drive(1'b1, l, k);
    tick();
    drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    tick();
    rst = 1'b0;
    check("reset_offset", off, 0);
    check("reset_hd", hd, 0);
    check("reset_flv", flv, 0);
    check("reset_len", len, 0);
    check("reset_runt_over", {runt, over}, 0);

    // 1: header threshold crossing on beat 3
    drive(1'b1, 1'b0, 8'h00);
    #1 check("t1_sof", sof, 1);
    tick(); drive(1'b0, 1'b0, 8'h00);
    check("t1_off1", off, 8);  check("t1_hd1", hd, 0);
    beat(1'b0, 8'h00);
    check("t1_off2", off, 16); check("t1_hd2", hd, 0);
    beat(1'b0, 8'h00);
    check("t1_off3", off, 24); check("t1_hd3", hd, 1); check("t1_pulse3", hdp, 1);
    beat(1'b0, 8'h00);
    check("t1_off4", off, 32); check("t1_hd4", hd, 1); check("t1_pulse4", hdp, 0);
    do_reset();

    // 2: partial last beat, threshold reached only on last beat
    beat(1'b0, 8'h00);
    beat(1'b0, 8'h00);
    check("t2_off2", off, 16);
    beat(1'b1, 8'h0F);
    check("t2_flv", flv, 1);
    check("t2_len", len, 20);
    check("t2_runt", runt, 0);
    check("t2_over", over, 0);
    check("t2_hd", hd, 0);
    check("t2_off", off, 0);
    tick();
    check("t2_flv_drop", flv, 0);
    check("t2_len_hold", len, 20);

    // 3: single-beat runt frame
    drive(1'b1, 1'b1, 8'h3F);
    #1 check("t3_sof", sof, 1);
    tick(); drive(1'b0, 1'b0, 8'h00);
    check("t3_flv", flv, 1);
    check("t3_len", len, 6);
    check("t3_runt", runt, 1);
    check("t3_hd", hd, 0);
    do_reset();

    // 4: saturation on the 64-byte instance
    for (int i = 0; i < 8; i++) beat(1'b0, 8'h00);
    check("t4_off8", off_s, 64);
    beat(1'b0, 8'h00);
    check("t4_off9_sat", off_s, 64);
    check("t4_off9_dflt", off, 72);
    beat(1'b1, 8'hFF);
    check("t4_flv", flv_s, 1);
    check("t4_len", len_s, 64);
    check("t4_over", over_s, 1);
    check("t4_len_dflt", len, 80);
    check("t4_over_dflt", over, 0);
    beat(1'b1, 8'hFF);
    check("t4_next_flv", flv_s, 1);
    check("t4_next_len", len_s, 8);
    check("t4_next_over", over_s, 0);
    check("t4_next_runt", runt_s, 1);

    // 5: reset mid-frame discards the frame
    beat(1'b0, 8'h00);
    beat(1'b0, 8'h00);
    check("t5_pre_off", off, 16);
    rst = 1'b1;
    #2;
    check("t5_rst_off", off, 0);
    check("t5_rst_hd", hd, 0);
    check("t5_rst_flv", flv, 0);
    tick();
    rst = 1'b0;
    tick();
    check("t5_no_flv", flv, 0);
    drive(1'b1, 1'b0, 8'h00);
    #1 check("t5_sof", sof, 1);
    tick(); drive(1'b0, 1'b0, 8'h00);
    beat(1'b0, 8'h00);
    beat(1'b1, 8'hFF);
    check("t5_flv", flv, 1);
    check("t5_len", len, 24);
    check("t5_runt", runt, 0);

    // 6: idle gaps hold state, back-to-back frames
    beat(1'b0, 8'h00);
    idle(2);
    check("t6_gap1_off", off, 8);
    beat(1'b0, 8'h00);
    idle(3);
    check("t6_gap2_off", off, 16);
    check("t6_gap2_hd", hd, 0);
    beat(1'b0, 8'h00);
    check("t6_hd", hd, 1);
    check("t6_pulse", hdp, 1);
    idle(1);
    check("t6_gap3_hd", hd, 1);
    check("t6_gap3_pulse", hdp, 0);
    check("t6_gap3_off", off, 24);
    beat(1'b1, 8'hFF);
    check("t6_flv", flv, 1);
    check("t6_len", len, 32);
    drive(1'b1, 1'b0, 8'h00);
    #1;
    check("t6_b2b_sof", sof, 1);
    check("t6_b2b_off0", off, 0);
    tick(); drive(1'b0, 1'b0, 8'h00);
    check("t6_b2b_off8", off, 8);
    check("t6_b2b_flv", flv, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
